register_file_mp: RTL and testbench

//  Parametrised multi-read-port integer register file with per-register busy scoreboard for the pipelined RV32I core.

---
 rtl/register_file_mp_pkg.sv | 11 +
 rtl/register_file_mp_if.sv | 38 +++
 rtl/register_file_mp_scoreboard.sv | 54 +++++
 rtl/register_file_mp.sv | 79 +++++++
 tb/tb_register_file_mp.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/register_file_mp_pkg.sv
// Shared constants for the multi-port register file.
// Default geometry and the hardwired-zero register index.
package register_file_mp_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NREGS_DEF  = 32;
    localparam int NRD_DEF    = 2;
    localparam int BYPASS_DEF = 1;
    localparam int ZERO_REG   = 0;

endpackage

// File: rtl/register_file_mp_if.sv
// Register file bus: writeback, issue, flush, read ports.
// master drives addresses/controls; slave returns data/busy/count.
interface register_file_mp_if
    import register_file_mp_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF
);
    localparam int AW = $clog2(NREGS);

    logic              we;
    logic [AW-1:0]     wa;
    logic [XLEN-1:0]   wd;
    logic [NRD*AW-1:0] ra;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]    rd_busy;
    logic              iss_valid;
    logic [AW-1:0]     iss_rd;
    logic              flush;
    logic [AW:0]       busy_cnt;
    logic              idle;

    modport master (
        output we, wa, wd, ra,
        output iss_valid, iss_rd, flush,
        input  rd, rd_busy,
        input  busy_cnt, idle
    );

    modport slave (
        input  we, wa, wd, ra,
        input  iss_valid, iss_rd, flush,
        output rd, rd_busy,
        output busy_cnt, idle
    );

endinterface

// File: rtl/register_file_mp_scoreboard.sv
// Busy scoreboard: one bit per register, flush > issue > write.
// Ports: write/issue/flush controls in; busy vector, count, idle out.
module register_file_mp_scoreboard
    import register_file_mp_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_rd,
    input  logic             flush,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      busy_cnt,
    output logic             idle
);

    logic [NREGS-1:0] busy_nx;
    logic [AW:0]      cnt_nx;

    // Issue is applied after the write clear so a
    // same-edge issue to the written reg keeps it busy.
    always_comb begin
        busy_nx = busy;
        cnt_nx  = '0;
        if (flush) begin
            busy_nx = '0;
        end else begin
            if (we && wa != AW'(ZERO_REG))
                busy_nx[wa] = 1'b0;
            if (iss_valid && iss_rd != AW'(ZERO_REG))
                busy_nx[iss_rd] = 1'b1;
        end
        busy_nx[ZERO_REG] = 1'b0;
        for (int i = 0; i < NREGS; i++)
            cnt_nx = cnt_nx + {{AW{1'b0}}, busy_nx[i]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nx;
            busy_cnt <= cnt_nx;
        end
    end

    assign idle = (busy_cnt == '0);

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port integer register file with busy scoreboard.
// Ports: clk, rst_n (async low), bus (slave side of register_file_mp_if).
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = NRD_DEF,
    parameter int BYPASS = BYPASS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    register_file_mp_if.slave bus
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [XLEN-1:0]  rdv  [NRD];
    logic             bsy  [NRD];

    // x0 is never written, so it stays at its reset value of 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (bus.we && bus.wa != AW'(ZERO_REG)) begin
            regs[bus.wa] <= bus.wd;
        end
    end

    register_file_mp_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (bus.we),
        .wa        (bus.wa),
        .iss_valid (bus.iss_valid),
        .iss_rd    (bus.iss_rd),
        .flush     (bus.flush),
        .busy      (busy),
        .busy_cnt  (bus.busy_cnt),
        .idle      (bus.idle)
    );

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] a;
        logic          nz;
        logic          hit;
        logic          iss_hit;

        assign a   = bus.ra[g*AW +: AW];
        assign nz  = (a != AW'(ZERO_REG));
        assign hit = (BYPASS != 0) && bus.we
                   && (bus.wa == a) && nz;
        assign iss_hit = bus.iss_valid
                       && (bus.iss_rd == a);

        // A forwarded write retires the producer, so busy
        // only survives if a new producer issues this cycle.
        assign rdv[g] = !nz ? '0
                      : hit ? bus.wd
                      : regs[a];
        assign bsy[g] = nz && (hit ? iss_hit : busy[a]);
    end

    always_comb begin
        bus.rd      = '0;
        bus.rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            bus.rd[i*XLEN +: XLEN] = rdv[i];
            bus.rd_busy[i]         = bsy[i];
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench: BYPASS=1 (dut a) and BYPASS=0 (dut b)
// share stimulus; expectations queued, checked at negedge.
module tb_register_file_mp;
    import register_file_mp_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    register_file_mp_if ifa ();
    register_file_mp_if ifb ();

    assign ifb.we        = ifa.we;
    assign ifb.wa        = ifa.wa;
    assign ifb.wd        = ifa.wd;
    assign ifb.ra        = ifa.ra;
    assign ifb.iss_valid = ifa.iss_valid;
    assign ifb.iss_rd    = ifa.iss_rd;
    assign ifb.flush     = ifa.flush;

    register_file_mp #(.BYPASS(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    register_file_mp #(.BYPASS(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    typedef enum int {
        K_RD0, K_RD1, K_BSY0, K_BSY1, K_CNT, K_IDLE
    } kind_e;

    typedef struct {
        string       name;
        int          dut;
        kind_e       kind;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int total = 0;
    int bad   = 0;
    logic [31:0] got;

    task automatic expv(string n, int d,
                        kind_e k, logic [31:0] v);
        exp_t x;
        x.name = n;
        x.dut  = d;
        x.kind = k;
        x.val  = v;
        q.push_back(x);
    endtask

    function automatic logic [31:0] observe(int d, kind_e k);
        logic [31:0] r;
        r = '0;
        case (k)
            K_RD0:  r = d == 0 ? ifa.rd[31:0]  : ifb.rd[31:0];
            K_RD1:  r = d == 0 ? ifa.rd[63:32] : ifb.rd[63:32];
            K_BSY0: r = {31'b0, d == 0 ? ifa.rd_busy[0]
                                       : ifb.rd_busy[0]};
            K_BSY1: r = {31'b0, d == 0 ? ifa.rd_busy[1]
                                       : ifb.rd_busy[1]};
            K_CNT:  r = {26'b0, d == 0 ? ifa.busy_cnt
                                       : ifb.busy_cnt};
            K_IDLE: r = {31'b0, d == 0 ? ifa.idle : ifb.idle};
            default: r = '0;
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0) begin
            e = q.pop_front();
            got = observe(e.dut, e.kind);
            total++;
            if (got !== e.val) begin
                bad++;
                $display("FAIL %s dut%0d got=%h want=%h",
                         e.name, e.dut, got, e.val);
            end
        end
    end

    task automatic drive(logic w, logic [4:0] a,
                         logic [31:0] d,
                         logic [4:0] r0, logic [4:0] r1,
                         logic iv, logic [4:0] ir,
                         logic fl);
        @(posedge clk);
        #1;
        ifa.we        = w;
        ifa.wa        = a;
        ifa.wd        = d;
        ifa.ra        = {r1, r0};
        ifa.iss_valid = iv;
        ifa.iss_rd    = ir;
        ifa.flush     = fl;
    endtask

    initial begin
        ifa.we = 0; ifa.wa = 0; ifa.wd = 0; ifa.ra = 0;
        ifa.iss_valid = 0; ifa.iss_rd = 0; ifa.flush = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state
        drive(0, 0, 0, 5, 7, 0, 0, 0);
        expv("rst_rd0", 0, K_RD0, 0);
        expv("rst_rd1", 0, K_RD1, 0);
        expv("rst_idle", 0, K_IDLE, 1);
        expv("rst_cnt", 0, K_CNT, 0);
        expv("rst_bsy", 0, K_BSY0, 0);

        // write x5 while reading it
        drive(1, 5, 32'h01234567, 5, 0, 0, 0, 0);
        expv("w5_byp", 0, K_RD0, 32'h01234567);
        expv("w5_nobyp", 1, K_RD0, 0);

        // write to x0 ignored
        drive(1, 0, 32'hFFFFFFFF, 5, 0, 0, 0, 0);
        expv("r5_a", 0, K_RD0, 32'h01234567);
        expv("r5_b", 1, K_RD0, 32'h01234567);
        expv("x0_byp_a", 0, K_RD1, 0);
        expv("x0_byp_b", 1, K_RD1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        expv("x0_read", 0, K_RD0, 0);

        // bypass on port 1
        drive(1, 7, 32'h88884444, 0, 7, 0, 0, 0);
        expv("byp_rd1", 0, K_RD1, 32'h88884444);
        expv("nobyp_rd1", 1, K_RD1, 0);

        // issue x7
        drive(0, 0, 0, 7, 0, 1, 7, 0);
        expv("r7", 0, K_RD0, 32'h88884444);
        expv("iss_pre_cnt", 0, K_CNT, 0);
        expv("iss_pre_bsy", 0, K_BSY0, 0);
        drive(0, 0, 0, 7, 7, 0, 0, 0);
        expv("bsy7_a", 0, K_BSY0, 1);
        expv("bsy7_alias", 0, K_BSY1, 1);
        expv("bsy7_b", 1, K_BSY0, 1);
        expv("cnt1", 0, K_CNT, 1);
        expv("idle0", 0, K_IDLE, 0);

        // writeback x7 masks busy when bypassed
        drive(1, 7, 32'h12, 7, 0, 0, 0, 0);
        expv("wb_bsy_a", 0, K_BSY0, 0);
        expv("wb_bsy_b", 1, K_BSY0, 1);
        expv("wb_rd_a", 0, K_RD0, 32'h12);
        expv("wb_rd_b", 1, K_RD0, 32'h88884444);
        expv("wb_cnt", 0, K_CNT, 1);
        drive(0, 0, 0, 7, 0, 0, 0, 0);
        expv("wb_cnt0", 0, K_CNT, 0);
        expv("wb_idle", 0, K_IDLE, 1);
        expv("wb_bsy_a2", 0, K_BSY0, 0);
        expv("wb_bsy_b2", 1, K_BSY0, 0);
        expv("wb_rd2", 0, K_RD0, 32'h12);

        // issue/write collision on x3
        drive(0, 0, 0, 3, 0, 1, 3, 0);
        expv("col_pre", 0, K_CNT, 0);
        drive(1, 3, 32'hABCD, 3, 0, 1, 3, 0);
        expv("col_bsy_a", 0, K_BSY0, 1);
        expv("col_bsy_b", 1, K_BSY0, 1);
        expv("col_rd", 0, K_RD0, 32'hABCD);
        expv("col_cnt", 0, K_CNT, 1);
        drive(0, 0, 0, 3, 0, 1, 0, 0);
        expv("col_keep", 0, K_BSY0, 1);
        expv("col_data_a", 0, K_RD0, 32'hABCD);
        expv("col_data_b", 1, K_RD0, 32'hABCD);
        expv("col_cnt2", 0, K_CNT, 1);
        drive(0, 0, 0, 3, 0, 0, 0, 0);
        expv("iss0_cnt", 0, K_CNT, 1);
        expv("iss0_bsy", 0, K_BSY0, 1);

        // fill then flush
        drive(0, 0, 0, 0, 0, 1, 1, 0);
        expv("fl_c1", 0, K_CNT, 1);
        drive(0, 0, 0, 0, 0, 1, 2, 0);
        expv("fl_c2", 0, K_CNT, 2);
        drive(0, 0, 0, 0, 0, 1, 3, 0);
        expv("fl_c3", 0, K_CNT, 3);
        drive(0, 0, 0, 2, 0, 1, 9, 1);
        expv("fl_pre", 0, K_CNT, 3);
        expv("fl_bsy2", 0, K_BSY0, 1);
        drive(0, 0, 0, 2, 9, 0, 0, 0);
        expv("fl_cnt", 0, K_CNT, 0);
        expv("fl_idle", 0, K_IDLE, 1);
        expv("fl_b2", 0, K_BSY0, 0);
        expv("fl_b9", 0, K_BSY1, 0);

        // async reset between edges
        drive(0, 0, 0, 5, 0, 1, 4, 0);
        expv("pre_rst_r5", 0, K_RD0, 32'h01234567);
        drive(0, 0, 0, 5, 4, 0, 0, 0);
        expv("pre_rst_cnt", 0, K_CNT, 1);
        expv("pre_rst_b4", 0, K_BSY1, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        expv("arst_r5_a", 0, K_RD0, 0);
        expv("arst_r5_b", 1, K_RD0, 0);
        expv("arst_cnt", 0, K_CNT, 0);
        expv("arst_idle", 0, K_IDLE, 1);
        expv("arst_b4", 0, K_BSY1, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        drive(0, 0, 0, 5, 4, 0, 0, 0);
        expv("post_r5", 0, K_RD0, 0);
        expv("post_cnt", 0, K_CNT, 0);
        expv("post_b4", 0, K_BSY1, 0);

        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
